complex_array_job_scheduler: RTL and testbench



---
 rtl/complex_array_job_scheduler_pkg.sv | 28 ++
 rtl/complex_array_job_scheduler_addsub_lane.sv | 88 ++++++++
 rtl/complex_array_job_scheduler.sv | 155 +++++++++++++++
 tb/tb_complex_array_job_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/complex_array_job_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : complex_array_job_scheduler_pkg
// Purpose  : Shared op codes, FSM states and element-count helper.
// Revision : 1.0 - initial release
// ============================================================================
package complex_array_job_scheduler_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_ROWS  = 2;
    localparam int DEFAULT_COLS  = 2;
    localparam int ELEMS         = DEFAULT_ROWS * DEFAULT_COLS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int elem_count(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage
`default_nettype wire

// File: rtl/complex_array_job_scheduler_addsub_lane.sv
`default_nettype none
// ============================================================================
// Module   : complex_addsub_lane
// Purpose  : Two-stage complex add/sub datapath with pass-through tags.
// Revision : 1.0 - initial release
// ============================================================================
module complex_addsub_lane
    import complex_array_job_scheduler_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IDX_W-1:0]     in_addr,
    input  logic                 in_id,
    input  logic                 in_op,
    input  logic [SIZE-1:0]      a_data,
    input  logic [SIZE-1:0]      b_data,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     out_addr,
    output logic                 out_id,
    output logic [3*SIZE-1:0]    out_data
);

    localparam int HALF  = SIZE / 2;
    localparam int RES_W = 3 * SIZE / 2;

    logic               r_s1_valid;
    logic [IDX_W-1:0]   r_s1_addr;
    logic               r_s1_id;
    logic               r_s1_op;
    logic [SIZE-1:0]    r_s1_a;
    logic [SIZE-1:0]    r_s1_b;

    logic [RES_W-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
    logic [RES_W-1:0]   w_re, w_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_id    <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_addr  <= in_addr;
            r_s1_id    <= in_id;
            r_s1_op    <= in_op;
            r_s1_a     <= a_data;
            r_s1_b     <= b_data;
        end
    end

    // Halves are zero-extended, so subtraction wraps modulo 2**RES_W.
    always_comb begin
        w_a_re = RES_W'(r_s1_a[SIZE-1:HALF]);
        w_a_im = RES_W'(r_s1_a[HALF-1:0]);
        w_b_re = RES_W'(r_s1_b[SIZE-1:HALF]);
        w_b_im = RES_W'(r_s1_b[HALF-1:0]);
        if (r_s1_op == OP_SUB) begin
            w_re = w_a_re - w_b_re;
            w_im = w_a_im - w_b_im;
        end else begin
            w_re = w_a_re + w_b_re;
            w_im = w_a_im + w_b_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_id    <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= r_s1_valid;
            out_addr  <= r_s1_addr;
            out_id    <= r_s1_id;
            out_data  <= {w_re, w_im};
        end
    end

endmodule
`default_nettype wire

// File: rtl/complex_array_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : complex_array_job_scheduler
// Purpose  : Round-robin scheduler sharing one complex add/sub lane.
// Revision : 1.0 - initial release
// ============================================================================
module complex_array_job_scheduler
    import complex_array_job_scheduler_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int SIZE  = 16,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [1:0]           op_sel,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic                 busy,
    output logic                 rd_en,
    output logic [IDX_W-1:0]     rd_addr,
    input  logic [SIZE-1:0]      a_data,
    input  logic [SIZE-1:0]      b_data,
    output logic                 wr_en,
    output logic [IDX_W-1:0]     wr_addr,
    output logic [3*SIZE-1:0]    wr_data,
    output logic                 wr_id
);

    localparam int                 JOB_ELEMS = elem_count(ROWS, COLS);
    localparam logic [IDX_W-1:0]   LAST_ADDR = IDX_W'(JOB_ELEMS - 1);

    state_t             r_state, w_state;
    logic               r_id, w_id;
    logic               r_op, w_op;
    logic               r_last, w_last;
    logic [1:0]         r_gnt, w_gnt;
    logic [1:0]         r_done, w_done;
    logic               r_busy, w_busy;
    logic               r_rd_en, w_rd_en;
    logic [IDX_W-1:0]   r_rd_addr, w_rd_addr;
    logic               r_drain, w_drain;
    logic               w_pick;

    // On a tie the requester not served last wins.
    assign w_pick = (req == 2'b11) ? ~r_last : req[1];

    always_comb begin
        w_state   = r_state;
        w_id      = r_id;
        w_op      = r_op;
        w_last    = r_last;
        w_gnt     = r_gnt;
        w_done    = 2'b00;
        w_rd_en   = 1'b0;
        w_rd_addr = r_rd_addr;
        w_drain   = r_drain;
        case (r_state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    w_state   = ST_ISSUE;
                    w_id      = w_pick;
                    w_op      = op_sel[w_pick];
                    w_last    = w_pick;
                    w_gnt     = w_pick ? 2'b10 : 2'b01;
                    w_rd_en   = 1'b1;
                    w_rd_addr = '0;
                end
            end
            ST_ISSUE: begin
                if (r_rd_addr == LAST_ADDR) begin
                    w_state   = ST_DRAIN;
                    w_rd_addr = '0;
                    w_drain   = 1'b0;
                end else begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = r_rd_addr + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                // Two drain cycles cover the lane latency.
                if (r_drain) begin
                    w_state = ST_DONE;
                    w_gnt   = 2'b00;
                    w_done  = r_id ? 2'b10 : 2'b01;
                    w_drain = 1'b0;
                end else begin
                    w_drain = 1'b1;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
                w_gnt   = 2'b00;
            end
        endcase
        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_id      <= 1'b0;
            r_op      <= OP_ADD;
            r_last    <= 1'b1;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_busy    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_drain   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_id      <= w_id;
            r_op      <= w_op;
            r_last    <= w_last;
            r_gnt     <= w_gnt;
            r_done    <= w_done;
            r_busy    <= w_busy;
            r_rd_en   <= w_rd_en;
            r_rd_addr <= w_rd_addr;
            r_drain   <= w_drain;
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign busy    = r_busy;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;

    complex_addsub_lane #(
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_rd_en),
        .in_addr   (r_rd_addr),
        .in_id     (r_id),
        .in_op     (r_op),
        .a_data    (a_data),
        .b_data    (b_data),
        .out_valid (wr_en),
        .out_addr  (wr_addr),
        .out_id    (wr_id),
        .out_data  (wr_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_complex_array_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_array_job_scheduler
// Purpose  : Self-checking bench for complex_array_job_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_complex_array_job_scheduler;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  op_sel;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        busy;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [47:0] wr_data;
    logic        wr_id;

    logic [15:0] a_mem [N];
    logic [15:0] b_mem [N];
    logic [47:0] exp_data [N];

    int checks   = 0;
    int failures = 0;
    int last_served;

    complex_array_job_scheduler dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op_sel  (op_sel),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .a_data  (a_data),
        .b_data  (b_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_id   (wr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_data = a_mem[rd_addr];
    assign b_data = b_mem[rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: each half treated as an unsigned integer, result kept mod 2**24.
    function automatic logic [47:0] model(input logic [15:0] a, input logic [15:0] b, input int op);
        int ar, ai, br, bi, re, im;
        logic [31:0] re_v, im_v;
        ar = int'(a[15:8]); ai = int'(a[7:0]);
        br = int'(b[15:8]); bi = int'(b[7:0]);
        re = (op == 1) ? ar - br : ar + br;
        im = (op == 1) ? ai - bi : ai + bi;
        re_v = re;
        im_v = im;
        return {re_v[23:0], im_v[23:0]};
    endfunction

    task automatic run_job(input logic [1:0] r, input logic [1:0] ops, input int exp_wait,
                           input bit disturb, input bit use_model, input string tag);
        int id, op, w;
        logic [1:0] oh;
        bit exp_wr;
        id = (r == 2'b11) ? (1 - last_served) : (r[1] ? 1 : 0);
        oh = (id == 1) ? 2'b10 : 2'b01;
        op = int'(ops[id]);
        if (use_model)
            for (int i = 0; i < N; i++) exp_data[i] = model(a_mem[i], b_mem[i], op);
        req    = r;
        op_sel = ops;
        w = 0;
        @(negedge clk);
        while (gnt == 2'b00 && w < 20) begin
            chk($sformatf("%s_idle_quiet", tag), {62'd0, wr_en | (done != 2'b00), busy}, 64'd0);
            w++;
            @(negedge clk);
        end
        if (gnt == 2'b00) begin
            chk($sformatf("%s_grant_timeout", tag), 64'd0, 64'd1);
            return;
        end
        if (exp_wait >= 0) chk($sformatf("%s_idle_gap", tag), 64'(w), 64'(exp_wait));
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            if (disturb && k == 1) begin
                req[id]    = 1'b0;
                op_sel[id] = ~op_sel[id];
            end
            exp_wr = (k >= 2 && k <= 5);
            chk($sformatf("%s_gnt_c%0d", tag, k), 64'(gnt), (k < 6) ? 64'(oh) : 64'd0);
            chk($sformatf("%s_done_c%0d", tag, k), 64'(done), (k == 6) ? 64'(oh) : 64'd0);
            chk($sformatf("%s_busy_c%0d", tag, k), 64'(busy), 64'd1);
            chk($sformatf("%s_wren_c%0d", tag, k), 64'(wr_en), 64'(exp_wr));
            if (exp_wr) begin
                chk($sformatf("%s_wraddr_c%0d", tag, k), 64'(wr_addr), 64'(k - 2));
                chk($sformatf("%s_wrdata_c%0d", tag, k), 64'(wr_data), 64'(exp_data[k - 2]));
                chk($sformatf("%s_wrid_c%0d", tag, k), 64'(wr_id), 64'(id));
            end
        end
        last_served = id;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  ops;
        logic [15:0] a;
        logic [15:0] b;
        logic [47:0] exp;
        bit          disturb;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{2'b01, 2'b00, 16'h0101, 16'h0101, 48'h000002_000002, 1'b0};
        vecs[1] = '{2'b10, 2'b10, 16'h0503, 16'h0102, 48'h000004_000001, 1'b0};
        vecs[2] = '{2'b10, 2'b10, 16'h0000, 16'h0101, 48'hFFFFFF_FFFFFF, 1'b0};
        vecs[3] = '{2'b01, 2'b00, 16'hFFFF, 16'hFFFF, 48'h0001FE_0001FE, 1'b0};
        vecs[4] = '{2'b01, 2'b00, 16'h0503, 16'h0102, 48'h000006_000005, 1'b1};

        rst_n = 1'b0;
        req = 2'b00;
        op_sel = 2'b00;
        last_served = 1;
        for (int i = 0; i < N; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
        repeat (3) @(negedge clk);
        chk("reset_outputs", {30'd0, gnt, done, busy, rd_en, rd_addr, wr_en, wr_addr, wr_id, 21'd0},
            64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++) begin
                a_mem[i] = vecs[v].a;
                b_mem[i] = vecs[v].b;
                exp_data[i] = vecs[v].exp;
            end
            run_job(vecs[v].req, vecs[v].ops, -1, vecs[v].disturb, 1'b0, $sformatf("vec%0d", v));
            req = 2'b00;
        end

        // Reset during DRAIN: everything clears, no done, requester 0 wins afterwards.
        for (int i = 0; i < N; i++) begin a_mem[i] = 16'($urandom); b_mem[i] = 16'($urandom); end
        req = 2'b10;
        op_sel = 2'b00;
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (gnt == 2'b00 && t < 20) begin t++; @(negedge clk); end
            chk("rst_job_granted", 64'(gnt), 64'b10);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {30'd0, gnt, done, busy, rd_en, rd_addr, wr_en, wr_addr, wr_id, 21'd0},
            64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        req = 2'b11;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", {62'd0, wr_en, done != 2'b00}, 64'd0);
        end
        rst_n = 1'b1;
        last_served = 1;

        // Contention with req=11 held: 01, 10, 01 with one idle cycle between jobs.
        run_job(2'b11, 2'b10, 0, 1'b0, 1'b1, "cont0");
        run_job(2'b11, 2'b10, 1, 1'b0, 1'b1, "cont1");
        run_job(2'b11, 2'b01, 1, 1'b0, 1'b1, "cont2");
        req = 2'b00;

        for (int j = 0; j < 12; j++) begin
            logic [1:0] r;
            for (int i = 0; i < N; i++) begin
                a_mem[i] = 16'($urandom);
                b_mem[i] = 16'($urandom);
            end
            r = 2'($urandom_range(1, 3));
            run_job(r, 2'($urandom), -1, 1'b0, 1'b1, $sformatf("rnd%0d", j));
            req = 2'b00;
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
